// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with parallel load, terminal count and wrap pulse.
// Define UDC_SATURATE_EN to make the counter saturate at 0 / MODULUS-1 instead of wrapping.
module sync_updown_counter #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // 64-bit modulus so that MODULUS = 2^32 with WIDTH = 32 is still representable.
    localparam logic [63:0]      MOD_EXT  = 64'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'sd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             load_err_r;

    logic [WIDTH-1:0] q_next_s;
    logic             wrap_next_s;
    logic             load_err_next_s;
    logic             at_max_s;
    logic             at_zero_s;

    function automatic logic din_in_range(input logic [WIDTH-1:0] v);
        din_in_range = (64'(v) < MOD_EXT);
    endfunction

    assign at_max_s  = (q_r == MAX_VAL);
    assign at_zero_s = (q_r == ZERO_VAL);

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        q_next_s        = q_r;
        wrap_next_s     = 1'b0;
        load_err_next_s = 1'b0;
        if (load) begin
            if (din_in_range(din)) begin
                q_next_s = din;
            end else begin
                q_next_s        = MAX_VAL;
                load_err_next_s = 1'b1;
            end
        end else if (en) begin
            case (up)
                1'b1: begin
                    if (at_max_s) begin
`ifdef UDC_SATURATE_EN
                        q_next_s    = MAX_VAL;
`else
                        q_next_s    = ZERO_VAL;
                        wrap_next_s = 1'b1;
`endif
                    end else begin
                        q_next_s = q_r + ONE_VAL;
                    end
                end
                1'b0: begin
                    if (at_zero_s) begin
`ifdef UDC_SATURATE_EN
                        q_next_s    = ZERO_VAL;
`else
                        q_next_s    = MAX_VAL;
                        wrap_next_s = 1'b1;
`endif
                    end else begin
                        q_next_s = q_r - ONE_VAL;
                    end
                end
                default: begin
                    q_next_s = q_r;
                end
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // Count state and the one-cycle status pulses, all aligned with the new q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r        <= RST_Q;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            q_r        <= q_next_s;
            wrap_r     <= wrap_next_s;
            load_err_r <= load_err_next_s;
        end
    end

    // tc is deliberately unregistered so a cascaded stage steps on the same edge.
    assign tc       = en & ((up & at_max_s) | (~up & at_zero_s));
    assign q        = q_r;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Parametrised synchronous up/down counter, the successor to the fixed 4-bit T-flip-flop down counter.
- Adds configurable width and modulus, run-time direction, count enable, parallel load, terminal-count output for cascading, and a wrap pulse.
- Used standalone or chained (tc of stage N drives en of stage N+1) to build BCD/decade and multi-digit counters.

Parameters:
- WIDTH, 4, counter bit width; legal 1..32.
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2^WIDTH.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; advances one step per clock when high.
- up  input  1  direction; 1 = increment, 0 = decrement. Sampled each clock.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational, for cascading.
- wrap  output  1  registered one-cycle pulse; q has just wrapped.
- load_err  output  1  registered one-cycle pulse; last load value was out of range.

Behaviour:
- Reset: rst high forces, immediately and asynchronously, q = RESET_VAL, wrap = 0, load_err = 0. The reset takes effect mid-count at any time. The first update after release happens on the first rising clk edge with rst low.
- Priority at each rising edge is rst > load > en. With load high, en and up are ignored.
- Load:
  - If din < MODULUS: q <= din, load_err <= 0.
  - If din >= MODULUS: q <= MODULUS-1 (clamp), load_err <= 1.
  - wrap <= 0 on any load.
- Count (en=1, load=0):
  - up=1: q <= q+1 if q != MODULUS-1, else q <= 0 and wrap <= 1.
  - up=0: q <= q-1 if q != 0, else q <= MODULUS-1 and wrap <= 1.
  - load_err <= 0.
- Hold (en=0, load=0): q unchanged; wrap <= 0; load_err <= 0.
- wrap and load_err are high for exactly one cycle, aligned with the cycle in which q shows the new value.
- tc = en & ((up & q == MODULUS-1) | (~up & q == 0)). It is purely combinational, with no register stage, so a chained stage advances on the same edge that wraps this stage.
- Arithmetic: modulo-MODULUS only. No intermediate value ever reaches or exceeds MODULUS, and no carry beyond WIDTH bits.
- Direction change: flipping up between consecutive enabled cycles takes effect on the next edge with no lost or extra step. Example: q=5, up then down gives 6 then 5.
- MODULUS = 2^WIDTH: wrap comparison still uses MODULUS-1 (all ones); the result is identical to natural binary rollover.
- Latency: count/load to q is 1 clock; tc has 0 clock latency from q, en and up.

Optional Feature:
- Macro: UDC_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - wrap is tied to 0.
  - tc keeps the same definition, so it flags "at limit".
  - Load and clamp behaviour are unchanged.
- Not defined: wrap-around behaviour exactly as described above.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated):
- Reset then en=1, up=1 for 12 clocks -> q = 1,2,...,9,0,1,2; wrap high only in the cycle q=0; tc high while q=9.
- Load din=3, then en=1, up=0 for 5 clocks -> q = 3,2,1,0,9,8; wrap pulses with q=9; tc high while q=0 and up=0.
- Load din=12 -> q=9, load_err high for 1 cycle. Then load din=4 -> q=4, load_err 0.
- Assert rst asynchronously between edges while q=7 -> q=0 before the next edge with no clock required. After release, the first enabled edge gives q=1.
- Two instances chained (tc0 -> en1), up=1, 25 clocks from reset -> {q1,q0} = 2,5; q1 increments only on q0's 9->0 edge.
- With UDC_SATURATE_EN: up=1 from q=8 for 4 clocks -> q = 9,9,9,9, wrap stays 0, tc=1. Then up=0 from q=1 for 3 clocks -> q = 0,0,0.
